// File: rtl/spi_adc_sequencer_pkg.sv
// Shared definitions for the SPI ADC frame sequencer: state encoding,
// frame geometry and the sample-field extraction helper.
package spi_adc_sequencer_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int SAMPLE_BITS = 12;
  localparam int SAMPLE_MSB  = 13;
  localparam int SAMPLE_LSB  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } seq_state_e;

  // Leading and trailing padding bits of the ADC frame are dropped here.
  function automatic logic [SAMPLE_BITS-1:0] sample_of(input logic [FRAME_BITS-1:0] frame);
    return frame[SAMPLE_MSB:SAMPLE_LSB];
  endfunction

endpackage

// File: rtl/spi_adc_sequencer_shift.sv
// Serial-in, parallel-out register for the ADC frame; MSB arrives first.
module spi_shift_in
  import spi_adc_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] dout
);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      dout <= '0;
    end else if (en) begin
      dout <= {dout[FRAME_BITS-2:0], din};
    end
  end

endmodule

// File: rtl/spi_adc_sequencer.sv
// SPI (CPOL=0) ADC frame sequencer with a one-deep sample register and sticky overrun.
// Optional macro SPI_ADC_SEQUENCER_MISO_SYNC_EN adds a 2-flop miso synchronizer (CLK_DIV >= 3).
module spi_adc_sequencer
  import spi_adc_sequencer_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic                   clk,
  input  logic                   rst_a,
  input  logic                   start,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   cs_n,
  output logic                   busy,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic [2:0]             state_dbg
);

  localparam logic [8:0] DIV_LAST   = 9'(CLK_DIV - 1);
  localparam logic [8:0] SETUP_LAST = 9'(CS_SETUP - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST   = 4'(FRAME_BITS - 1);

  seq_state_e            state, state_nxt;
  logic [8:0]            cnt, cnt_nxt;
  logic [3:0]            bit_cnt, bit_nxt;
  logic                  sclk_nxt;
  logic                  rise;
  logic                  frame_done;
  logic                  cap_en;
  logic                  cap_bit;
  logic [FRAME_BITS-1:0] frame;

  assign state_dbg = state;

`ifdef SPI_ADC_SEQUENCER_MISO_SYNC_EN
  logic [1:0] miso_sync;
  logic [1:0] rise_dly;

  // The capture strobe is delayed to line up with the synchronized bit.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      miso_sync <= '0;
      rise_dly  <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      rise_dly  <= {rise_dly[0], rise};
    end
  end

  assign cap_en  = rise_dly[1];
  assign cap_bit = miso_sync[1];
`else
  assign cap_en  = rise;
  assign cap_bit = miso;
`endif

  spi_shift_in u_shift (
    .clk  (clk),
    .rst_a(rst_a),
    .en   (cap_en),
    .din  (cap_bit),
    .dout (frame)
  );

  // cnt times SETUP/HOLD/GAP and the SCLK half-period; sclk itself is the phase bit.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_cnt;
    sclk_nxt   = sclk;
    rise       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = '0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
            rise     = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_nxt   = '0;
              state_nxt = HOLD;
            end else begin
              bit_nxt = bit_cnt + 4'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      HOLD: begin
        if (cnt == SETUP_LAST) begin
          state_nxt  = GAP;
          cnt_nxt    = '0;
          frame_done = 1'b1;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        bit_nxt   = '0;
        sclk_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      sclk    <= sclk_nxt;
      cs_n    <= !(state_nxt inside {SETUP, SHIFT, HOLD});
      busy    <= (state_nxt != IDLE);
    end
  end

  // A completed frame loads unless an unconsumed sample is still waiting.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_done && (!sample_valid || sample_ready)) begin
      sample_data  <= sample_of(frame);
      sample_valid <= 1'b1;
    end else begin
      if (frame_done) begin
        overrun <= 1'b1;
      end
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
